// File: rtl/resil_stage_ctrl.sv
// Purpose : sequencer for one timing-resilient stage (latch enable, error sample, recovery, 4-phase handshakes).
// Latency : lreq at edge E -> go_ml in E+1, sample in E+2+SAMPLE_DLY, rreq/lack in E+3+SAMPLE_DLY (+RECOV_CYC on error).
// Backpressure: one token in flight; lreq is only accepted in IDLE, OUT holds until rack, RLS until rack=0 and lreq=0.
// Optional feature: define RESIL_DOUBLE_ERR_EN to add err_fatal and the HALT state on a double error.
module resil_stage_ctrl #(
    parameter int SAMPLE_DLY = 2,   // 0..15
    parameter int RECOV_CYC  = 1,   // 1..15
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,       // synchronous, active low
    input  logic                 lreq,
    output logic                 lack,
    output logic                 rreq,
    input  logic                 rack,
    input  logic                 err0,
    input  logic                 err1,
    output logic                 go_ml,
    output logic                 sample,
    output logic                 busy,
`ifdef RESIL_DOUBLE_ERR_EN
    output logic                 err_fatal,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] SD_L = 4'(SAMPLE_DLY);
    localparam logic [3:0] RC_L = 4'(RECOV_CYC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_WAIT  = 3'd2,
        S_SAMP  = 3'd3,
        S_RECOV = 3'd4,
        S_OUT   = 3'd5,
`ifdef RESIL_DOUBLE_ERR_EN
        S_RLS   = 3'd6,
        S_HALT  = 3'd7
`else
        S_RLS   = 3'd6
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       err_any;

    assign err_any = err0 | err1;

`ifdef RESIL_DOUBLE_ERR_EN
    logic err_double;
    assign err_double = err0 & err1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Shared down-counter: sample delay in WAIT, recovery length in RECOV
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else begin
            case (state)
                S_CAPT:  cnt <= SD_L;
                S_WAIT:  cnt <= cnt - 4'd1;
                S_SAMP:  cnt <= RC_L;
                S_RECOV: cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Saturating error counter, updated only on the edge that ends SAMP
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (state == S_SAMP && err_any && err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

`ifdef RESIL_DOUBLE_ERR_EN
    // Sticky fatal flag for a simultaneous falling and rising transition error
    always_ff @(posedge clk) begin
        if (!rst)                             err_fatal <= 1'b0;
        else if (state == S_SAMP && err_double) err_fatal <= 1'b1;
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (lreq) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = (SAMPLE_DLY == 0) ? S_SAMP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_SAMP;
            S_SAMP: begin
`ifdef RESIL_DOUBLE_ERR_EN
                if (err_double)   state_nxt = S_HALT;
                else if (err_any) state_nxt = S_RECOV;
                else              state_nxt = S_OUT;
`else
                // A double error is recovered like a single one
                state_nxt = err_any ? S_RECOV : S_OUT;
`endif
            end
            S_RECOV: if (cnt == 4'd1) state_nxt = S_OUT;
            S_OUT:   if (rack) state_nxt = S_RLS;
            S_RLS:   if (!rack && !lreq) state_nxt = S_IDLE;
`ifdef RESIL_DOUBLE_ERR_EN
            S_HALT:  state_nxt = S_HALT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        go_ml  = 1'b0;
        sample = 1'b0;
        rreq   = 1'b0;
        lack   = 1'b0;
        busy   = (state != S_IDLE);
        case (state)
            S_CAPT:  go_ml  = 1'b1;
            S_SAMP:  sample = 1'b1;
            S_RECOV: go_ml  = 1'b1;
            S_OUT: begin
                rreq = 1'b1;
                lack = 1'b1;
            end
            S_RLS:   lack   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_resil_stage_ctrl.sv
// Purpose : randomized bench for resil_stage_ctrl against a token-timeline reference model.
// Latency : outputs are compared 1 time unit after every rising edge.
// Backpressure: rack, lreq and error flags are driven randomly, including protocol violations and resets.
module tb_resil_stage_ctrl;

    localparam int SD   = 2;
    localparam int RC   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NCYC = 3000;

`ifdef RESIL_DOUBLE_ERR_EN
    localparam bit FATAL_EN = 1'b1;
    logic err_fatal;
`else
    localparam bit FATAL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, lreq, rack, err0, err1;
    logic          lack, rreq, go_ml, sample, busy;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    resil_stage_ctrl #(.SAMPLE_DLY(SD), .RECOV_CYC(RC), .ERR_CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .lreq    (lreq),
        .lack    (lack),
        .rreq    (rreq),
        .rack    (rack),
        .err0    (err0),
        .err1    (err1),
        .go_ml   (go_ml),
        .sample  (sample),
        .busy    (busy),
`ifdef RESIL_DOUBLE_ERR_EN
        .err_fatal(err_fatal),
`endif
        .err_cnt (err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a token is tracked by its age m_k (cycles since accept)
    // and its handshake phase m_ph (0 = processing, 1 = request out, 2 = release).
    bit m_act, m_err, m_halt, m_fatal;
    int m_k, m_ph, m_cnt;

    task model_step;
        if (!rst) begin
            m_act = 0; m_err = 0; m_halt = 0; m_fatal = 0;
            m_k = 0; m_ph = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_act = 0;
        end else if (!m_act) begin
            if (lreq) begin
                m_act = 1; m_k = 1; m_err = 0; m_ph = 0;
            end
        end else if (m_ph == 0) begin
            if (m_k == SD + 2 && (err0 || err1)) begin
                if (m_cnt < CMAX) m_cnt++;
                if (FATAL_EN && err0 && err1) begin
                    m_halt = 1; m_fatal = 1; m_act = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_k++;
            if (m_act && m_k == SD + 3 + (m_err ? RC : 0)) m_ph = 1;
        end else if (m_ph == 1) begin
            if (rack) m_ph = 2;
        end else begin
            if (!rack && !lreq) m_act = 0;
        end
    endtask

    task check_all;
        bit e_go, e_smp;
        e_go  = m_act && m_ph == 0 &&
                (m_k == 1 || (m_err && m_k >= SD + 3 && m_k < SD + 3 + RC));
        e_smp = m_act && m_ph == 0 && m_k == SD + 2;
        chk("go_ml",   32'(go_ml),   32'(e_go));
        chk("sample",  32'(sample),  32'(e_smp));
        chk("rreq",    32'(rreq),    32'(m_act && m_ph == 1));
        chk("lack",    32'(lack),    32'(m_act && m_ph >= 1));
        chk("busy",    32'(busy),    32'(m_act || m_halt));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`ifdef RESIL_DOUBLE_ERR_EN
        chk("err_fatal", 32'(err_fatal), 32'(m_fatal));
`endif
    endtask

    initial begin
        // Reset held for two edges with lreq asserted, then released with lreq still high
        rst = 1'b0; lreq = 1'b1; rack = 1'b0; err0 = 1'b0; err1 = 1'b0;
        m_act = 0; m_err = 0; m_halt = 0; m_fatal = 0; m_k = 0; m_ph = 0; m_cnt = 0;
        for (int i = 0; i < NCYC; i++) begin
            cyc = i;
            if (i >= 2) begin
                rst = (i < 200) ? 1'b1 : ($urandom_range(0, 59) != 0);
                if (!m_act)        lreq = ($urandom_range(0, 2) != 0);
                else if (m_ph == 2) lreq = ($urandom_range(0, 2) == 0);
                else               lreq = 1'($urandom_range(0, 1));
                rack = 1'($urandom_range(0, 1));
                if (i < 600) begin
                    // Long run of single errors drives the counter into saturation
                    err0 = 1'b0;
                    err1 = 1'b1;
                end else begin
                    err0 = ($urandom_range(0, 3) == 0);
                    err1 = ($urandom_range(0, 3) == 0);
                end
            end else begin
                rst = (i < 2) ? 1'b0 : 1'b1;
            end
            if (i == 1) begin
                @(posedge clk);
                model_step();
                #1;
                check_all();
                rst = 1'b1;
                lreq = 1'b1;
                continue;
            end
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
